// File: rtl/obi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_arb_pkg
// Description : Shared types and helpers for the OBI round-robin arbiter.
//               - OBI_DATA_W : data bus width of every OBI port
//               - OBI_ADDR_W : widest address the request struct carries
//               - port_idx_w : bits needed to hold a port index (min 1)
//               - obi_req_t  : one request beat {addr, we, be, wdata}
// Revision    : 1.0 - initial release
// ============================================================================
package obi_arb_pkg;

    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = OBI_DATA_W / 8;
    localparam int OBI_ADDR_W = 32;

    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

endpackage
`default_nettype wire

// File: rtl/obi_arb_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : obi_arb_rsp_fifo
// Description : Small in-order FIFO holding the port index of every granted,
//               not yet answered transaction. Head is read combinationally.
//   clk   in  clock
//   rst   in  synchronous active-high reset (empties the FIFO)
//   push  in  write din (ignored when full)
//   pop   in  drop head (ignored when empty)
//   din   in  port index to store
//   dout  out port index at the head
//   full  out DEPTH entries stored
//   empty out no entries stored
//   count out number of entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module obi_arb_rsp_fifo #(
    parameter  int DEPTH   = 2,
    parameter  int WIDTH   = 2,
    localparam int C_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [C_CNT_W-1:0] count
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    assign full      = (r_count == C_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_rr_arbiter
// Description : Shares one OBI port between NUM_PORTS requesters with
//               round-robin grant, an OBI request-stability lock and up to
//               MAX_OUTSTANDING in-order responses routed back by a FIFO of
//               port indices.
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i  per-port request channel
//   gnt_o                           per-port grant (same cycle as soc_gnt_i)
//   rvalid_o/rdata_o                per-port response (rdata 0 when idle)
//   soc_req_o..soc_wdata_o          unified request channel
//   soc_gnt_i                       unified grant
//   soc_rvalid_i/soc_rdata_i        unified response
//   rsp_err_o                       sticky: response with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 3,
    parameter int SOC_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_PORTS-1:0]                      req_i,
    input  logic [NUM_PORTS-1:0][SOC_ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]                      we_i,
    input  logic [NUM_PORTS-1:0][OBI_BE_W-1:0]        be_i,
    input  logic [NUM_PORTS-1:0][OBI_DATA_W-1:0]      wdata_i,
    output logic [NUM_PORTS-1:0]                      gnt_o,
    output logic [NUM_PORTS-1:0]                      rvalid_o,
    output logic [NUM_PORTS-1:0][OBI_DATA_W-1:0]      rdata_o,
    output logic                                      soc_req_o,
    output logic [SOC_ADDR_WIDTH-1:0]                 soc_addr_o,
    output logic                                      soc_we_o,
    output logic [OBI_BE_W-1:0]                       soc_be_o,
    output logic [OBI_DATA_W-1:0]                     soc_wdata_o,
    input  logic                                      soc_gnt_i,
    input  logic                                      soc_rvalid_i,
    input  logic [OBI_DATA_W-1:0]                     soc_rdata_i,
    output logic                                      rsp_err_o
);

    localparam int C_IDX_W = port_idx_w(NUM_PORTS);
    localparam int C_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [C_IDX_W-1:0] r_rr_ptr;
    logic               r_lock_vld;
    logic [C_IDX_W-1:0] r_lock_port;
    logic               r_err;

    logic [C_IDX_W-1:0] w_sel;
    logic [C_IDX_W-1:0] w_next_ptr;
    logic               w_soc_req;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic [C_IDX_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic [C_CNT_W-1:0] w_count;
    obi_req_t           w_sel_req;

    // First requesting port at or after ptr, wrapping; returns ptr when idle
    // (harmless: req_i[ptr] is then 0, so nothing is issued).
    function automatic logic [C_IDX_W-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [C_IDX_W-1:0]   ptr
    );
        logic [C_IDX_W-1:0] pick;
        logic [C_IDX_W-1:0] cand;
        logic               found;
        int                 idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            cand = C_IDX_W'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // A stalled request must be re-presented unchanged, so a held lock
    // overrides the round-robin search.
    assign w_sel = r_lock_vld ? r_lock_port : rr_pick(req_i, r_rr_ptr);

    assign w_next_ptr = (w_sel == C_IDX_W'(NUM_PORTS - 1)) ? '0 : w_sel + C_IDX_W'(1);

    // Full FIFO blocks issue even if a pop happens this cycle: no bypass.
    assign w_soc_req = !rst_i && req_i[w_sel] && (w_count < C_CNT_W'(MAX_OUTSTANDING));
    assign w_grant   = w_soc_req && soc_gnt_i;
    assign w_push    = w_grant && !w_full;
    assign w_pop     = !rst_i && soc_rvalid_i && !w_empty;

    always_comb begin
        w_sel_req = '0;
        if (w_soc_req) begin
            w_sel_req.addr  = OBI_ADDR_W'(addr_i[w_sel]);
            w_sel_req.we    = we_i[w_sel];
            w_sel_req.be    = be_i[w_sel];
            w_sel_req.wdata = wdata_i[w_sel];
        end
    end

    assign soc_req_o   = w_soc_req;
    assign soc_addr_o  = w_sel_req.addr[SOC_ADDR_WIDTH-1:0];
    assign soc_we_o    = w_sel_req.we;
    assign soc_be_o    = w_sel_req.be;
    assign soc_wdata_o = w_sel_req.wdata;
    assign rsp_err_o   = r_err && !rst_i;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign gnt_o[p]    = w_grant && (w_sel == C_IDX_W'(p));
            assign rvalid_o[p] = w_pop && (w_head == C_IDX_W'(p));
            assign rdata_o[p]  = rvalid_o[p] ? soc_rdata_i : '0;
        end
    endgenerate

    obi_arb_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (C_IDX_W)
    ) u_rsp_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_sel),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_lock_vld  <= 1'b0;
            r_lock_port <= '0;
            r_err       <= 1'b0;
        end else begin
            if (soc_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
            if (w_grant) begin
                r_rr_ptr   <= w_next_ptr;
                r_lock_vld <= 1'b0;
            end else if (w_soc_req) begin
                r_lock_vld  <= 1'b1;
                r_lock_port <= w_sel;
            end else begin
                // Locked requester withdrew: re-arbitrate next cycle.
                r_lock_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_rr_arbiter
// Description : Self-checking bench for obi_rr_arbiter: reset, a vector table
//               for round-robin order, hand sequences for lock, outstanding
//               limit, push+pop, spurious response and reset mid-transaction,
//               then random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

    localparam int NP  = 3;
    localparam int MAX = 2;

    logic                 clk = 1'b0;
    logic                 r_rst;
    logic [NP-1:0]        r_req;
    logic [NP-1:0][31:0]  r_addr;
    logic [NP-1:0]        r_we;
    logic [NP-1:0][3:0]   r_be;
    logic [NP-1:0][31:0]  r_wdata;
    logic                 r_soc_gnt;
    logic                 r_soc_rvalid;
    logic [31:0]          r_soc_rdata;

    logic [NP-1:0]        w_gnt;
    logic [NP-1:0]        w_rvalid;
    logic [NP-1:0][31:0]  w_rdata;
    logic                 w_soc_req;
    logic [31:0]          w_soc_addr;
    logic                 w_soc_we;
    logic [3:0]           w_soc_be;
    logic [31:0]          w_soc_wdata;
    logic                 w_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: next round-robin start, held port (-1 none),
    // queue of ports awaiting a response, sticky error.
    int m_rr;
    int m_lock;
    int m_q[$];
    bit m_err;

    always #5 clk = ~clk;

    obi_rr_arbiter #(
        .NUM_PORTS       (NP),
        .SOC_ADDR_WIDTH  (32),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk_i        (clk),
        .rst_i        (r_rst),
        .req_i        (r_req),
        .addr_i       (r_addr),
        .we_i         (r_we),
        .be_i         (r_be),
        .wdata_i      (r_wdata),
        .gnt_o        (w_gnt),
        .rvalid_o     (w_rvalid),
        .rdata_o      (w_rdata),
        .soc_req_o    (w_soc_req),
        .soc_addr_o   (w_soc_addr),
        .soc_we_o     (w_soc_we),
        .soc_be_o     (w_soc_be),
        .soc_wdata_o  (w_soc_wdata),
        .soc_gnt_i    (r_soc_gnt),
        .soc_rvalid_i (r_soc_rvalid),
        .soc_rdata_i  (r_soc_rdata),
        .rsp_err_o    (w_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_sel();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < NP; k++) begin
            if (r_req[(m_rr + k) % NP]) return (m_rr + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit m_issue();
        int s;
        s = m_sel();
        return !r_rst && (s >= 0) && r_req[s] && (m_q.size() < MAX);
    endfunction

    task automatic model_check(input string tag);
        int          s;
        bit          issue;
        int          pp;
        logic [2:0]  one;
        logic [2:0]  eg;
        logic [2:0]  ev;
        one   = 3'b001;
        s     = m_sel();
        issue = m_issue();
        eg    = (issue && r_soc_gnt) ? (one << s) : 3'b000;
        pp    = (!r_rst && r_soc_rvalid && m_q.size() > 0) ? m_q[0] : -1;
        ev    = (pp >= 0) ? (one << pp) : 3'b000;
        chk({tag, ".gnt"},       w_gnt, eg);
        chk({tag, ".soc_req"},   w_soc_req, issue);
        chk({tag, ".soc_addr"},  w_soc_addr,  issue ? r_addr[s]  : 32'h0);
        chk({tag, ".soc_we"},    w_soc_we,    issue ? r_we[s]    : 1'b0);
        chk({tag, ".soc_be"},    w_soc_be,    issue ? r_be[s]    : 4'h0);
        chk({tag, ".soc_wdata"}, w_soc_wdata, issue ? r_wdata[s] : 32'h0);
        chk({tag, ".rvalid"},    w_rvalid, ev);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s.rdata%0d", tag, p), w_rdata[p], (pp == p) ? r_soc_rdata : 32'h0);
        end
        chk({tag, ".rsp_err"},   w_err, r_rst ? 1'b0 : m_err);
    endtask

    task automatic model_update();
        int s;
        bit issue;
        if (r_rst) begin
            m_rr   = 0;
            m_lock = -1;
            m_q.delete();
            m_err  = 1'b0;
        end else begin
            s     = m_sel();
            issue = m_issue();
            if (r_soc_rvalid) begin
                if (m_q.size() == 0) m_err = 1'b1;
                else void'(m_q.pop_front());
            end
            if (issue && r_soc_gnt) begin
                m_q.push_back(s);
                m_rr   = (s + 1) % NP;
                m_lock = -1;
            end else if (issue) begin
                m_lock = s;
            end else begin
                m_lock = -1;
            end
        end
    endtask

    // Drive one cycle's inputs and compare against the model at the negedge;
    // adv() then clocks the DUT and the model together.
    task automatic step(input logic rst, input logic [2:0] req, input logic gnt,
                        input logic rv, input logic [31:0] rdata, input string tag);
        r_rst        = rst;
        r_req        = req;
        r_soc_gnt    = gnt;
        r_soc_rvalid = rv;
        r_soc_rdata  = rdata;
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [2:0]  exp_gnt;
        logic        exp_soc_req;
        logic [2:0]  exp_rvalid;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // Round-robin with all ports requesting and one-cycle responses.
        tbl[0] = '{3'b111, 1'b1, 1'b0, 32'h0000_0000, 3'b001, 1'b1, 3'b000};
        tbl[1] = '{3'b111, 1'b1, 1'b1, 32'hC0DE_0000, 3'b010, 1'b1, 3'b001};
        tbl[2] = '{3'b111, 1'b1, 1'b1, 32'hC0DE_0001, 3'b100, 1'b1, 3'b010};
        tbl[3] = '{3'b111, 1'b1, 1'b1, 32'hC0DE_0002, 3'b001, 1'b1, 3'b100};
        tbl[4] = '{3'b000, 1'b0, 1'b1, 32'hC0DE_0003, 3'b000, 1'b0, 3'b001};

        m_rr = 0; m_lock = -1; m_err = 1'b0;
        for (int p = 0; p < NP; p++) begin
            r_addr[p]  = 32'h1000_0000 + 32'(p) * 32'h100;
            r_we[p]    = p[0];
            r_be[p]    = 4'hF >> p;
            r_wdata[p] = 32'hD000_0000 + 32'(p);
        end

        // Reset ignores requests and responses.
        step(1'b1, 3'b111, 1'b1, 1'b1, 32'hDEAD_BEEF, "rst0");
        chk("rst.soc_req", w_soc_req, 1'b0);
        chk("rst.gnt", w_gnt, 3'b000);
        chk("rst.rvalid", w_rvalid, 3'b000);
        adv();
        step(1'b1, 3'b111, 1'b0, 1'b0, 32'h0, "rst1");
        chk("rst.rsp_err", w_err, 1'b0);
        adv();

        for (int i = 0; i < 5; i++) begin
            step(1'b0, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, $sformatf("rr%0d", i));
            chk($sformatf("rr%0d.tbl_gnt", i), w_gnt, tbl[i].exp_gnt);
            chk($sformatf("rr%0d.tbl_soc_req", i), w_soc_req, tbl[i].exp_soc_req);
            chk($sformatf("rr%0d.tbl_rvalid", i), w_rvalid, tbl[i].exp_rvalid);
            adv();
        end

        // Lock: port1 stalls 3 cycles while port0 joins, granted on cycle 4.
        step(1'b0, 3'b010, 1'b0, 1'b0, 32'h0, "lk0");
        chk("lk0.addr", w_soc_addr, 32'h1000_0100);
        adv();
        for (int i = 1; i < 3; i++) begin
            step(1'b0, 3'b011, 1'b0, 1'b0, 32'h0, "lk");
            chk("lk.addr", w_soc_addr, 32'h1000_0100);
            chk("lk.gnt", w_gnt, 3'b000);
            adv();
        end
        step(1'b0, 3'b011, 1'b1, 1'b0, 32'h0, "lk3");
        chk("lk3.gnt", w_gnt, 3'b010);
        chk("lk3.addr", w_soc_addr, 32'h1000_0100);
        adv();
        step(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0077, "lkr");
        chk("lkr.rvalid", w_rvalid, 3'b010);
        chk("lkr.rdata1", w_rdata[1], 32'h0000_0077);
        adv();

        // Locked requester withdraws: one idle cycle, then re-arbitration.
        step(1'b0, 3'b001, 1'b0, 1'b0, 32'h0, "ld0");
        chk("ld0.soc_req", w_soc_req, 1'b1);
        adv();
        step(1'b0, 3'b100, 1'b0, 1'b0, 32'h0, "ld1");
        chk("ld1.soc_req", w_soc_req, 1'b0);
        adv();
        step(1'b0, 3'b100, 1'b1, 1'b0, 32'h0, "ld2");
        chk("ld2.gnt", w_gnt, 3'b100);
        adv();

        // Reset with a transaction in flight: its response is then spurious.
        step(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, "rm0");
        adv();
        step(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0099, "rm1");
        chk("rm1.rvalid", w_rvalid, 3'b000);
        adv();
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, "rm2");
        chk("rm2.rsp_err", w_err, 1'b1);
        adv();

        // Outstanding limit: two grants, then issue blocked until a response.
        step(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, "ol_rst");
        adv();
        step(1'b0, 3'b101, 1'b1, 1'b0, 32'h0, "ol0");
        chk("ol0.gnt", w_gnt, 3'b001);
        adv();
        step(1'b0, 3'b101, 1'b1, 1'b0, 32'h0, "ol1");
        chk("ol1.gnt", w_gnt, 3'b100);
        adv();
        step(1'b0, 3'b111, 1'b1, 1'b0, 32'h0, "ol2");
        chk("ol2.soc_req", w_soc_req, 1'b0);
        chk("ol2.gnt", w_gnt, 3'b000);
        adv();
        step(1'b0, 3'b111, 1'b0, 1'b1, 32'hA5A5_A5A5, "ol3");
        chk("ol3.rvalid", w_rvalid, 3'b001);
        chk("ol3.rdata0", w_rdata[0], 32'hA5A5_A5A5);
        chk("ol3.soc_req", w_soc_req, 1'b0);
        adv();
        step(1'b0, 3'b000, 1'b0, 1'b1, 32'h5A5A_5A5A, "ol4");
        chk("ol4.rvalid", w_rvalid, 3'b100);
        chk("ol4.rdata2", w_rdata[2], 32'h5A5A_5A5A);
        adv();

        // Push and pop in the same cycle.
        step(1'b0, 3'b001, 1'b1, 1'b0, 32'h0, "pp0");
        chk("pp0.gnt", w_gnt, 3'b001);
        adv();
        step(1'b0, 3'b010, 1'b1, 1'b1, 32'h1111_1111, "pp1");
        chk("pp1.rvalid", w_rvalid, 3'b001);
        chk("pp1.gnt", w_gnt, 3'b010);
        adv();
        step(1'b0, 3'b000, 1'b0, 1'b1, 32'h2222_2222, "pp2");
        chk("pp2.rvalid", w_rvalid, 3'b010);
        chk("pp2.rdata1", w_rdata[1], 32'h2222_2222);
        adv();

        // Spurious response: error sticks until reset.
        step(1'b0, 3'b000, 1'b0, 1'b1, 32'h3333_3333, "sp0");
        chk("sp0.rvalid", w_rvalid, 3'b000);
        chk("sp0.rsp_err", w_err, 1'b0);
        adv();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, "sp1");
            chk("sp1.rsp_err", w_err, 1'b1);
            adv();
        end
        step(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, "sp2");
        adv();
        step(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, "sp3");
        chk("sp3.rsp_err", w_err, 1'b0);
        adv();

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                r_addr[p]  = $urandom;
                r_we[p]    = 1'($urandom);
                r_be[p]    = 4'($urandom);
                r_wdata[p] = $urandom;
            end
            step(($urandom_range(0, 99) == 0),
                 3'($urandom),
                 ($urandom_range(0, 2) != 0),
                 (m_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 49) == 0),
                 $urandom,
                 "rnd");
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
